// File: rtl/cpu_defs_pkg.sv
// cpu_defs_pkg: shared opcode constants, ALU operation encodings, control
// unit state encodings and opcode class encodings. Used by the control unit,
// its decoder, the ALU and the CPU top level.
//
// Build option: CU_MPY_EN adds the MUL state used by the multi-cycle
// multiply. Without it, opcode 08 decodes as illegal.
package cpu_defs_pkg;

  localparam logic [7:0] OP_STORE  = 8'h01;
  localparam logic [7:0] OP_LOAD   = 8'h02;
  localparam logic [7:0] OP_ADD    = 8'h03;
  localparam logic [7:0] OP_SUB    = 8'h04;
  localparam logic [7:0] OP_JMPGEZ = 8'h05;
  localparam logic [7:0] OP_JMP    = 8'h06;
  localparam logic [7:0] OP_HALT   = 8'h07;
  localparam logic [7:0] OP_MPY    = 8'h08;
  localparam logic [7:0] OP_AND    = 8'h0A;
  localparam logic [7:0] OP_OR     = 8'h0B;
  localparam logic [7:0] OP_NOT    = 8'h0C;
  localparam logic [7:0] OP_SHR    = 8'h0D;
  localparam logic [7:0] OP_SHL    = 8'h0E;

  typedef enum logic [3:0] {
    ALU_PASS_B = 4'd0,
    ALU_ADD    = 4'd1,
    ALU_SUB    = 4'd2,
    ALU_AND    = 4'd3,
    ALU_OR     = 4'd4,
    ALU_NOT    = 4'd5,
    ALU_SHR    = 4'd6,
    ALU_SHL    = 4'd7,
    ALU_MPY    = 4'd8
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_F1   = 3'd0,
    ST_F2   = 3'd1,
    ST_F3   = 3'd2,
    ST_EX1  = 3'd3,
    ST_EX2  = 3'd4,
    ST_EX3  = 3'd5,
    ST_HALT = 3'd6
`ifdef CU_MPY_EN
    ,
    ST_MUL  = 3'd7
`endif
  } cu_state_e;

  typedef enum logic [2:0] {
    CLS_MEM_ALU = 3'd0,  // operand read from memory, then ALU into ACC
    CLS_REG_ALU = 3'd1,  // ACC-only ALU operation
    CLS_STORE   = 3'd2,
    CLS_JUMP    = 3'd3,
    CLS_HALT    = 3'd4,
    CLS_ILLEGAL = 3'd5
  } op_class_e;

endpackage

// File: rtl/cu_decoder.sv
// cu_decoder: combinational opcode classifier for the control unit.
//   opcode   in  8  instruction register contents
//   op_class out    instruction class driving the FSM's execute path
//   alu_sel  out 4  ALU operation the instruction uses
//   is_cond  out 1  jump is conditional on ACC sign (JMPGEZ)
// Build option: CU_MPY_EN makes opcode 08 a memory-ALU multiply; otherwise
// it falls through to illegal.
module cu_decoder
  import cpu_defs_pkg::*;
(
  input  logic [7:0] opcode,
  output op_class_e  op_class,
  output alu_op_e    alu_sel,
  output logic       is_cond
);

  always_comb begin
    op_class = CLS_ILLEGAL;
    alu_sel  = ALU_PASS_B;
    is_cond  = 1'b0;
    case (opcode)
      OP_STORE:  op_class = CLS_STORE;
      OP_LOAD:   op_class = CLS_MEM_ALU;
      OP_ADD:    begin op_class = CLS_MEM_ALU; alu_sel = ALU_ADD; end
      OP_SUB:    begin op_class = CLS_MEM_ALU; alu_sel = ALU_SUB; end
      OP_AND:    begin op_class = CLS_MEM_ALU; alu_sel = ALU_AND; end
      OP_OR:     begin op_class = CLS_MEM_ALU; alu_sel = ALU_OR;  end
`ifdef CU_MPY_EN
      OP_MPY:    begin op_class = CLS_MEM_ALU; alu_sel = ALU_MPY; end
`endif
      OP_NOT:    begin op_class = CLS_REG_ALU; alu_sel = ALU_NOT; end
      OP_SHR:    begin op_class = CLS_REG_ALU; alu_sel = ALU_SHR; end
      OP_SHL:    begin op_class = CLS_REG_ALU; alu_sel = ALU_SHL; end
      OP_JMP:    op_class = CLS_JUMP;
      OP_JMPGEZ: begin op_class = CLS_JUMP; is_cond = 1'b1; end
      OP_HALT:   op_class = CLS_HALT;
      default:   op_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// control_unit: microsequencer for the accumulator CPU. Only the state is
// registered; every strobe is decoded combinationally from the state, the
// opcode class and the handshake inputs.
//   clk, rst          clock, synchronous active-high reset
//   opcode            IR contents, used from EX1 onward
//   acc_neg           ACC sign bit, gates JMPGEZ
//   mem_ready         memory access completion (sampled in F2, EX1, EX2)
//   alu_done          multiply completion (sampled in MUL)
//   c_*               datapath transfer strobes
//   alu_start, alu_op ALU control
//   halted            high in HALT
//   illegal_op        one-cycle pulse on an undefined opcode
// Build option: CU_MPY_EN enables the MUL state and the multiply path.
//
// state | meaning
// F1    | MAR <- PC
// F2    | instruction read, wait mem_ready, MBR <- mem, PC++
// F3    | IR <- MBR, MAR <- MBR (operand address)
// EX1   | per-class first execute step (operand read waits here)
// EX2   | STORE write wait, or BR <- MBR
// EX3   | ALU result into ACC, or multiply launch
// MUL   | wait for alu_done (CU_MPY_EN only)
// HALT  | parked until reset
module control_unit
  import cpu_defs_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] opcode,
  input  logic       acc_neg,
  input  logic       mem_ready,
  input  logic       alu_done,
  output logic       c_mar_from_pc,
  output logic       c_mar_from_mbr,
  output logic       c_mem_rd,
  output logic       c_mem_wr,
  output logic       c_mbr_from_mem,
  output logic       c_mbr_from_acc,
  output logic       c_pc_inc,
  output logic       c_pc_from_mbr,
  output logic       c_ir_load,
  output logic       c_br_from_mbr,
  output logic       c_acc_load,
  output logic       alu_start,
  output logic [3:0] alu_op,
  output logic       halted,
  output logic       illegal_op
);

  cu_state_e r_state;
  cu_state_e w_next;
  op_class_e w_class;
  alu_op_e   w_alu_sel;
  logic      w_cond;
  alu_op_e   w_alu_op;

`ifdef CU_MPY_EN
  logic      w_alu_start;
  assign alu_start = w_alu_start;
`else
  logic      w_unused_alu_done;
  assign w_unused_alu_done = alu_done;
  assign alu_start = 1'b0;
`endif

  assign alu_op = w_alu_op;

  cu_decoder u_dec (
    .opcode   (opcode),
    .op_class (w_class),
    .alu_sel  (w_alu_sel),
    .is_cond  (w_cond)
  );

  always_comb begin
    w_next         = r_state;
    c_mar_from_pc  = 1'b0;
    c_mar_from_mbr = 1'b0;
    c_mem_rd       = 1'b0;
    c_mem_wr       = 1'b0;
    c_mbr_from_mem = 1'b0;
    c_mbr_from_acc = 1'b0;
    c_pc_inc       = 1'b0;
    c_pc_from_mbr  = 1'b0;
    c_ir_load      = 1'b0;
    c_br_from_mbr  = 1'b0;
    c_acc_load     = 1'b0;
    w_alu_op       = ALU_PASS_B;
    halted         = 1'b0;
    illegal_op     = 1'b0;
`ifdef CU_MPY_EN
    w_alu_start    = 1'b0;
`endif

    case (r_state)
      ST_F1: begin
        c_mar_from_pc = 1'b1;
        w_next        = ST_F2;
      end
      ST_F2: begin
        c_mem_rd = 1'b1;
        if (mem_ready) begin
          c_mbr_from_mem = 1'b1;
          c_pc_inc       = 1'b1;
          w_next         = ST_F3;
        end
      end
      ST_F3: begin
        c_ir_load      = 1'b1;
        c_mar_from_mbr = 1'b1;
        w_next         = ST_EX1;
      end
      ST_EX1: begin
        case (w_class)
          CLS_STORE: begin
            c_mbr_from_acc = 1'b1;
            w_next         = ST_EX2;
          end
          CLS_MEM_ALU: begin
            c_mem_rd = 1'b1;
            if (mem_ready) begin
              c_mbr_from_mem = 1'b1;
              w_next         = ST_EX2;
            end
          end
          CLS_JUMP: begin
            // JMPGEZ falls through when ACC is negative
            c_pc_from_mbr = !(w_cond && acc_neg);
            w_next        = ST_F1;
          end
          CLS_REG_ALU: begin
            w_alu_op   = w_alu_sel;
            c_acc_load = 1'b1;
            w_next     = ST_F1;
          end
          CLS_HALT: w_next = ST_HALT;
          default: begin
            illegal_op = 1'b1;
            w_next     = ST_F1;
          end
        endcase
      end
      ST_EX2: begin
        if (w_class == CLS_STORE) begin
          c_mem_wr = 1'b1;
          if (mem_ready) w_next = ST_F1;
        end else begin
          c_br_from_mbr = 1'b1;
          w_next        = ST_EX3;
        end
      end
      ST_EX3: begin
`ifdef CU_MPY_EN
        if (w_alu_sel == ALU_MPY) begin
          w_alu_start = 1'b1;
          w_next      = ST_MUL;
        end else
`endif
        begin
          w_alu_op   = w_alu_sel;
          c_acc_load = 1'b1;
          w_next     = ST_F1;
        end
      end
`ifdef CU_MPY_EN
      ST_MUL: begin
        w_alu_op = ALU_MPY;
        if (alu_done) begin
          c_acc_load = 1'b1;
          w_next     = ST_F1;
        end
      end
`endif
      ST_HALT: halted = 1'b1;
      default: w_next = ST_F1;
    endcase

    // Reset masks every output so an in-flight access never completes.
    if (rst) begin
      w_next         = ST_F1;
      c_mar_from_pc  = 1'b0;
      c_mar_from_mbr = 1'b0;
      c_mem_rd       = 1'b0;
      c_mem_wr       = 1'b0;
      c_mbr_from_mem = 1'b0;
      c_mbr_from_acc = 1'b0;
      c_pc_inc       = 1'b0;
      c_pc_from_mbr  = 1'b0;
      c_ir_load      = 1'b0;
      c_br_from_mbr  = 1'b0;
      c_acc_load     = 1'b0;
      w_alu_op       = ALU_PASS_B;
      halted         = 1'b0;
      illegal_op     = 1'b0;
`ifdef CU_MPY_EN
      w_alu_start    = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    r_state <= w_next;
  end

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] opcode;
  logic       acc_neg;
  logic       mem_ready;
  logic       alu_done;
  logic       c_mar_from_pc, c_mar_from_mbr, c_mem_rd, c_mem_wr;
  logic       c_mbr_from_mem, c_mbr_from_acc, c_pc_inc, c_pc_from_mbr;
  logic       c_ir_load, c_br_from_mbr, c_acc_load, alu_start;
  logic [3:0] alu_op;
  logic       halted, illegal_op;

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .rst(rst), .opcode(opcode), .acc_neg(acc_neg),
    .mem_ready(mem_ready), .alu_done(alu_done),
    .c_mar_from_pc(c_mar_from_pc), .c_mar_from_mbr(c_mar_from_mbr),
    .c_mem_rd(c_mem_rd), .c_mem_wr(c_mem_wr),
    .c_mbr_from_mem(c_mbr_from_mem), .c_mbr_from_acc(c_mbr_from_acc),
    .c_pc_inc(c_pc_inc), .c_pc_from_mbr(c_pc_from_mbr),
    .c_ir_load(c_ir_load), .c_br_from_mbr(c_br_from_mbr),
    .c_acc_load(c_acc_load), .alu_start(alu_start), .alu_op(alu_op),
    .halted(halted), .illegal_op(illegal_op)
  );

  localparam logic [17:0] M_MAR_PC  = 18'h00001;
  localparam logic [17:0] M_MAR_MBR = 18'h00002;
  localparam logic [17:0] M_MEM_RD  = 18'h00004;
  localparam logic [17:0] M_MEM_WR  = 18'h00008;
  localparam logic [17:0] M_MBR_MEM = 18'h00010;
  localparam logic [17:0] M_MBR_ACC = 18'h00020;
  localparam logic [17:0] M_PC_INC  = 18'h00040;
  localparam logic [17:0] M_PC_MBR  = 18'h00080;
  localparam logic [17:0] M_IR      = 18'h00100;
  localparam logic [17:0] M_BR      = 18'h00200;
  localparam logic [17:0] M_ACC     = 18'h00400;
  localparam logic [17:0] M_ASTART  = 18'h00800;
  localparam logic [17:0] M_HALT    = 18'h10000;
  localparam logic [17:0] M_ILL     = 18'h20000;

  typedef struct {
    logic [7:0]  op;
    logic        neg;
    logic        mr;
    logic        ad;
    logic [17:0] exp;
  } cyc_t;

  typedef struct {
    logic [7:0] op;
    logic       neg;
    int         wf;
    int         we;
    int         d;
    int         n_acc;
    int         n_pcm;
    int         n_ill;
    int         n_inc;
  } vec_t;

  cyc_t q[$];
  int total = 0;
  int bad = 0;
  int cnt_acc, cnt_pcm, cnt_ill, cnt_inc;

  function automatic logic [17:0] outs();
    return {illegal_op, halted, alu_op, alu_start, c_acc_load, c_br_from_mbr,
            c_ir_load, c_pc_from_mbr, c_pc_inc, c_mbr_from_acc, c_mbr_from_mem,
            c_mem_wr, c_mem_rd, c_mar_from_mbr, c_mar_from_pc};
  endfunction

  function automatic logic [17:0] aop(int code);
    return 18'(code) << 12;
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push(logic [7:0] op, logic neg, logic mr, logic ad,
                               logic [17:0] exp);
    cyc_t c;
    c.op = op; c.neg = neg; c.mr = mr; c.ad = ad; c.exp = exp;
    q.push_back(c);
  endfunction

  // Fetch: opcode is not yet meaningful, so drive garbage on it.
  function automatic void push_fetch(logic neg, int wf);
    push(8'($urandom), neg, rb(), rb(), M_MAR_PC);
    for (int i = 0; i < wf; i++) push(8'($urandom), neg, 1'b0, rb(), M_MEM_RD);
    push(8'($urandom), neg, 1'b1, rb(), M_MEM_RD | M_MBR_MEM | M_PC_INC);
    push(8'($urandom), neg, rb(), rb(), M_IR | M_MAR_MBR);
  endfunction

  // Instruction semantics written out as the cycle-by-cycle strobe trace.
  function automatic void push_exec(logic [7:0] op, logic neg, int we, int d);
    int code;
    bit memop;
    bit mpy;
`ifdef CU_MPY_EN
    mpy = (op == 8'h08);
`else
    mpy = 1'b0;
`endif
    memop = mpy;
    code = 0;
    case (op)
      8'h02: begin memop = 1; code = 0; end
      8'h03: begin memop = 1; code = 1; end
      8'h04: begin memop = 1; code = 2; end
      8'h0A: begin memop = 1; code = 3; end
      8'h0B: begin memop = 1; code = 4; end
      default: ;
    endcase
    if (op == 8'h01) begin
      push(op, neg, rb(), rb(), M_MBR_ACC);
      for (int i = 0; i < we; i++) push(op, neg, 1'b0, rb(), M_MEM_WR);
      push(op, neg, 1'b1, rb(), M_MEM_WR);
    end else if (memop) begin
      for (int i = 0; i < we; i++) push(op, neg, 1'b0, rb(), M_MEM_RD);
      push(op, neg, 1'b1, rb(), M_MEM_RD | M_MBR_MEM);
      push(op, neg, rb(), rb(), M_BR);
      if (mpy) begin
        push(op, neg, rb(), rb(), M_ASTART);
        for (int i = 0; i < d; i++) push(op, neg, rb(), 1'b0, aop(8));
        push(op, neg, rb(), 1'b1, aop(8) | M_ACC);
      end else begin
        push(op, neg, rb(), rb(), M_ACC | aop(code));
      end
    end else begin
      case (op)
        8'h05: push(op, neg, rb(), rb(), neg ? 18'h0 : M_PC_MBR);
        8'h06: push(op, neg, rb(), rb(), M_PC_MBR);
        8'h07: push(op, neg, rb(), rb(), 18'h0);
        8'h0C: push(op, neg, rb(), rb(), M_ACC | aop(5));
        8'h0D: push(op, neg, rb(), rb(), M_ACC | aop(6));
        8'h0E: push(op, neg, rb(), rb(), M_ACC | aop(7));
        default: push(op, neg, rb(), rb(), M_ILL);
      endcase
    end
  endfunction

  // Entered and left at a falling edge; drives each cycle, samples 1ns later.
  task automatic play(string tag);
    cyc_t c;
    logic [17:0] o;
    while (q.size() > 0) begin
      c = q.pop_front();
      opcode = c.op; acc_neg = c.neg; mem_ready = c.mr; alu_done = c.ad;
      #1;
      o = outs();
      check(tag, 32'(o), 32'(c.exp));
      check("rd_wr_excl", 32'(c_mem_rd & c_mem_wr), 32'h0);
      cnt_acc += int'(c_acc_load);
      cnt_pcm += int'(c_pc_from_mbr);
      cnt_ill += int'(illegal_op);
      cnt_inc += int'(c_pc_inc);
      @(negedge clk);
    end
  endtask

  task automatic clr_cnt();
    cnt_acc = 0; cnt_pcm = 0; cnt_ill = 0; cnt_inc = 0;
  endtask

  vec_t tbl[17];
  logic [7:0] legal[12];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    legal = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h08,
              8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E};
    //          op     neg wf we d  acc pcm ill inc
    tbl[0]  = '{8'h02, 1'b0, 0, 0, 0, 1, 0, 0, 1};
    tbl[1]  = '{8'h03, 1'b0, 3, 0, 0, 1, 0, 0, 1};
    tbl[2]  = '{8'h01, 1'b0, 0, 2, 0, 0, 0, 0, 1};
    tbl[3]  = '{8'h05, 1'b1, 0, 0, 0, 0, 0, 0, 1};
    tbl[4]  = '{8'h05, 1'b0, 1, 0, 0, 0, 1, 0, 1};
    tbl[5]  = '{8'h06, 1'b1, 0, 0, 0, 0, 1, 0, 1};
    tbl[6]  = '{8'h0C, 1'b0, 0, 0, 0, 1, 0, 0, 1};
    tbl[7]  = '{8'h0D, 1'b1, 2, 0, 0, 1, 0, 0, 1};
    tbl[8]  = '{8'h0E, 1'b0, 0, 0, 0, 1, 0, 0, 1};
    tbl[9]  = '{8'h04, 1'b0, 1, 2, 0, 1, 0, 0, 1};
    tbl[10] = '{8'h0A, 1'b0, 0, 1, 0, 1, 0, 0, 1};
    tbl[11] = '{8'h0B, 1'b1, 0, 3, 0, 1, 0, 0, 1};
    tbl[12] = '{8'h00, 1'b0, 0, 0, 0, 0, 0, 1, 1};
    tbl[13] = '{8'h09, 1'b0, 1, 0, 0, 0, 0, 1, 1};
    tbl[14] = '{8'hFF, 1'b0, 0, 0, 0, 0, 0, 1, 1};
`ifdef CU_MPY_EN
    tbl[15] = '{8'h08, 1'b0, 0, 0, 4, 1, 0, 0, 1};
`else
    tbl[15] = '{8'h08, 1'b0, 0, 0, 4, 0, 0, 1, 1};
`endif
    tbl[16] = '{8'h01, 1'b1, 1, 0, 0, 0, 0, 0, 1};

    rst = 1'b1; opcode = 8'h00; acc_neg = 1'b0; mem_ready = 1'b1; alu_done = 1'b1;
    @(negedge clk);
    #1 check("reset_outs", 32'(outs()), 32'h0);
    @(negedge clk);
    #1 check("reset_outs2", 32'(outs()), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table
    foreach (tbl[k]) begin
      clr_cnt();
      push_fetch(tbl[k].neg, tbl[k].wf);
      push_exec(tbl[k].op, tbl[k].neg, tbl[k].we, tbl[k].d);
      play($sformatf("vec%0d_cycle", k));
      check($sformatf("vec%0d_acc_load", k), 32'(cnt_acc), 32'(tbl[k].n_acc));
      check($sformatf("vec%0d_pc_from_mbr", k), 32'(cnt_pcm), 32'(tbl[k].n_pcm));
      check($sformatf("vec%0d_illegal", k), 32'(cnt_ill), 32'(tbl[k].n_ill));
      check($sformatf("vec%0d_pc_inc", k), 32'(cnt_inc), 32'(tbl[k].n_inc));
    end

    // HALT: parked for 20 cycles, then a one-cycle reset.
    push_fetch(1'b0, 1);
    push_exec(8'h07, 1'b0, 0, 0);
    for (int i = 0; i < 20; i++) push(8'h07, rb(), rb(), rb(), M_HALT);
    play("halt_cycle");
    rst = 1'b1; mem_ready = 1'b1;
    #1 check("halt_rst_outs", 32'(outs()), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    push_fetch(1'b0, 0);
    push_exec(8'h02, 1'b0, 0, 0);
    play("after_halt_cycle");

    // Reset while STORE waits for write completion.
    push_fetch(1'b0, 0);
    push(8'h01, 1'b0, rb(), rb(), M_MBR_ACC);
    push(8'h01, 1'b0, 1'b0, rb(), M_MEM_WR);
    push(8'h01, 1'b0, 1'b0, rb(), M_MEM_WR);
    play("store_pre_rst");
    rst = 1'b1; mem_ready = 1'b1;
    #1 check("store_rst_outs", 32'(outs()), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    opcode = 8'h01; mem_ready = 1'b1;
    #1 check("store_rst_next_f1", 32'(outs()), 32'(M_MAR_PC));
    check("store_rst_no_wr", 32'(c_mem_wr), 32'h0);
    @(negedge clk);
    push(8'h01, 1'b0, 1'b1, rb(), M_MEM_RD | M_MBR_MEM | M_PC_INC);
    push(8'h01, 1'b0, rb(), rb(), M_IR | M_MAR_MBR);
    push_exec(8'h06, 1'b0, 0, 0);
    play("store_rst_resume");

    // Randomized instruction stream
    for (int n = 0; n < 150; n++) begin
      logic [7:0] op;
      logic neg;
      if ($urandom_range(0, 3) == 0) op = 8'($urandom_range(0, 255));
      else op = legal[$urandom_range(0, 11)];
      if (op == 8'h07) op = 8'h02;
      neg = rb();
      push_fetch(neg, $urandom_range(0, 3));
      push_exec(op, neg, $urandom_range(0, 3), $urandom_range(0, 5));
      play("rand_cycle");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
